// File: rtl/exec_phase_ctrl_if.sv
// Sequencer <-> execute-phase controller link.
// Strobes and memory data flow in; SEQTYPE and DONE flow back.
interface exec_phase_ctrl_if;
  logic        RUNNING;
  logic        STB_FETCH;
  logic        STB_AUTO1;
  logic        STB_AUTO2;
  logic        STB_IND;
  logic        STB_1;
  logic        STB_2;
  logic        STB_3;
  logic        STB_4;
  logic        STB_5;
  logic        STB_6;
  logic [11:0] MDATA;
  logic [1:0]  SEQTYPE;
  logic        DONE;

  modport master (
    output RUNNING,
    output STB_FETCH, STB_AUTO1, STB_AUTO2, STB_IND,
    output STB_1, STB_2, STB_3, STB_4, STB_5, STB_6,
    output MDATA,
    input  SEQTYPE, DONE
  );

  modport slave (
    input  RUNNING,
    input  STB_FETCH, STB_AUTO1, STB_AUTO2, STB_IND,
    input  STB_1, STB_2, STB_3, STB_4, STB_5, STB_6,
    input  MDATA,
    output SEQTYPE, DONE
  );
endinterface

// File: rtl/exec_phase_ctrl.sv
// Execute-phase controller: latches IR, decodes SEQTYPE, ends instructions.
// Optional STB_6 watchdog with sticky FAULT: define EXEC_WATCHDOG_EN.
module exec_phase_ctrl #(
  parameter int unsigned ICNT_W  = 16,
  parameter logic [3:0]  AUTO_LO = 4'b0001
) (
  input  logic              CLK,
  input  logic              RESET,
  exec_phase_ctrl_if.slave  bus,
  output logic [11:0]       IR,
  output logic [2:0]        OPCODE,
  output logic [2:0]        PHASE,
  output logic [ICNT_W-1:0] ICOUNT,
  output logic              FAULT
);

  function automatic logic [1:0] decode(
    input logic [11:0] x
  );
    logic mri;
    logic ind;
    logic aut;
    mri = (x[11:9] < 3'd6);
    ind = mri & x[8];
    aut = ind & ~x[7] & (x[6:3] == AUTO_LO);
    return {aut, ind};
  endfunction

  function automatic logic [2:0] need_of(
    input logic [2:0] op
  );
    logic [2:0] n;
    unique case (op)
      3'd0:    n = 3'd2;
      3'd1:    n = 3'd2;
      3'd2:    n = 3'd3;
      3'd3:    n = 3'd1;
      3'd4:    n = 3'd2;
      3'd5:    n = 3'd1;
      3'd6:    n = 3'd1;
      default: n = 3'd3;
    endcase
    return n;
  endfunction

  logic [11:0]       ir_q, ir_d;
  logic [2:0]        phase_q, phase_d;
  logic [ICNT_W-1:0] icount_q, icount_d;
  logic              valid_q, valid_d;
  logic [2:0]        sel_k;
  logic              hit;
  logic              done_c;
`ifdef EXEC_WATCHDOG_EN
  logic              fault_q, fault_d;
`endif

  // Lowest-numbered strobe wins; fetch and bookkeeping strobes map to 0.
  always_comb begin
    sel_k = 3'd0;
    priority case (1'b1)
      bus.STB_FETCH: sel_k = 3'd0;
      bus.STB_AUTO1: sel_k = 3'd0;
      bus.STB_AUTO2: sel_k = 3'd0;
      bus.STB_IND:   sel_k = 3'd0;
      bus.STB_1:     sel_k = 3'd1;
      bus.STB_2:     sel_k = 3'd2;
      bus.STB_3:     sel_k = 3'd3;
      bus.STB_4:     sel_k = 3'd4;
      bus.STB_5:     sel_k = 3'd5;
      bus.STB_6:     sel_k = 3'd6;
      default:       sel_k = 3'd0;
    endcase
  end

  assign hit = (sel_k != 3'd0)
             & (sel_k == need_of(ir_q[11:9]));

  always_comb begin
    ir_d     = ir_q;
    phase_d  = phase_q;
    valid_d  = valid_q;
    icount_d = icount_q;
    done_c   = 1'b0;
`ifdef EXEC_WATCHDOG_EN
    fault_d  = fault_q;
`endif
    if (bus.STB_FETCH) begin
      ir_d    = bus.MDATA;
      phase_d = 3'd0;
      valid_d = 1'b1;
    end else if (sel_k != 3'd0) begin
      phase_d = sel_k;
      if (bus.RUNNING && valid_q && hit) begin
        done_c   = 1'b1;
        icount_d = icount_q + 1'b1;
        valid_d  = 1'b0;
      end
`ifdef EXEC_WATCHDOG_EN
      else if (bus.RUNNING && sel_k == 3'd6) begin
        done_c  = 1'b1;
        fault_d = 1'b1;
        valid_d = 1'b0;
      end
`endif
    end
    if (RESET) done_c = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ir_q     <= '0;
      phase_q  <= '0;
      icount_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      ir_q     <= ir_d;
      phase_q  <= phase_d;
      icount_q <= icount_d;
      valid_q  <= valid_d;
    end
  end

`ifdef EXEC_WATCHDOG_EN
  always_ff @(posedge CLK) begin
    if (RESET) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
  assign FAULT = fault_q;
`else
  assign FAULT = 1'b0;
`endif

  // Decode straight from MDATA in the fetch cycle so the sequencer sees it now.
  assign bus.SEQTYPE = bus.STB_FETCH ? decode(bus.MDATA)
                                     : decode(ir_q);
  assign bus.DONE    = done_c;
  assign IR          = ir_q;
  assign OPCODE      = ir_q[11:9];
  assign PHASE       = phase_q;
  assign ICOUNT      = icount_q;

endmodule

// File: doc/exec_phase_ctrl.md
Name: exec_phase_ctrl

Overview:
- Instruction-side counterpart of the step sequencer.
- Consumes the sequencer's phase strobes and memory data, and latches the instruction register at fetch.
- Supplies the sequencer with SEQTYPE ({instIsPPIND, instIsIND}) and with DONE, which ends the instruction after its last required execute phase.
- Also counts retired instructions and flags malformed phase sequences.

Parameters:
- ICNT_W, 16, width of the retired-instruction counter.
- AUTO_LO, 4'b0001, value of IR[6:3] that identifies the autoindex locations 0010–0017 (octal).

Ports:
- CLK  in  1  system clock; one clock, all state on rising edge.
- RESET  in  1  synchronous, active-high reset.
- RUNNING  in  1  sequencer run flag; DONE and counting are enabled only when high.
- STB_FETCH, STB_AUTO1, STB_AUTO2, STB_IND  in  1 each  phase strobes from the sequencer, one cycle wide.
- STB_1 .. STB_6  in  1 each  execute-phase strobes, one cycle wide.
- MDATA  in  12  memory read data; valid in the STB_FETCH cycle.
- SEQTYPE  out  2  {instIsPPIND, instIsIND} for the sequencer.
- DONE  out  1  end-of-instruction pulse to the sequencer.
- IR  out  12  latched instruction.
- OPCODE  out  3  IR[11:9].
- PHASE  out  3  number of execute phases completed in the current instruction (0–6).
- ICOUNT  out  ICNT_W  retired-instruction counter.
- FAULT  out  1  sticky watchdog flag.

Behaviour:
- Reset (synchronous): IR=0, PHASE=0, ICOUNT=0, FAULT=0, valid=0. DONE is 0 while RESET is high.
- Decode function D(x):
  - MRI = x[11:9] < 6; ind = MRI & x[8]; auto = ind & !x[7] & (x[6:3]==AUTO_LO).
  - D(x) = {auto, ind}.
  - Encoding 2'b10 is never produced.
- SEQTYPE is combinational: D(MDATA) when STB_FETCH=1, otherwise D(IR). The sequencer samples it on the STB_FETCH edge, so there is zero latency.
- On STB_FETCH: IR<=MDATA, PHASE<=0, valid<=1.
  - STB_FETCH has priority over every other input except RESET.
  - A fetch arriving mid-instruction restarts decoding with no DONE and no ICOUNT change.
- On STB_k (k=1..6): PHASE<=k.
- Required execute phases N(opcode): AND 2, TAD 2, ISZ 3, DCA 1, JMS 2, JMP 1, IOT 1, OPR 3.
- DONE = RUNNING & valid & STB_N. It is combinational and asserts in the same cycle as the final strobe, so the sequencer clears its step count on that edge.
  - On that edge: ICOUNT<=ICOUNT+1 (wraps at 2^ICNT_W-1 to 0), valid<=0.
- STB_AUTO1/2 and STB_IND do not change PHASE or IR; they are accepted only for phase bookkeeping.
- When RUNNING=0: strobes still update IR and PHASE, but DONE is held 0 and ICOUNT is frozen.
- Strobes with valid=0 (after reset, or after DONE and before the next fetch) never produce DONE without the watchdog.
- More than one strobe high in the same cycle cannot occur on a legal interface; if it does, the lowest-numbered phase wins, with STB_FETCH first.

Optional Feature:
- Macro: EXEC_WATCHDOG_EN.
- When defined: if STB_6 arrives and DONE would not otherwise assert (valid=0, or N not yet reached), DONE is forced for that cycle, FAULT<=1 (sticky until RESET), and ICOUNT is not incremented.
- When undefined: no forced DONE; FAULT is tied to 0.

Test Plan:
- TAD I 10: MDATA=o1410 with STB_FETCH -> SEQTYPE=2'b11 in that cycle, IR=o1410 next cycle; strobes STB_AUTO1..STB_IND, STB_1 -> DONE=0; STB_2 -> DONE=1, ICOUNT 0->1.
- DCA direct: MDATA=o3050 -> SEQTYPE=2'b00; DONE=1 coincident with STB_1, PHASE=1 afterwards.
- JMP I off-page: MDATA=o5600 -> SEQTYPE=2'b01 (page bit set, so no autoindex); DONE on STB_1.
- OPR: MDATA=o7200 -> SEQTYPE=2'b00; STB_1 and STB_2 give no DONE; STB_3 gives DONE; RUNNING=0 repeat -> DONE stays 0 and ICOUNT is unchanged.
- Watchdog (EXEC_WATCHDOG_EN defined): after RESET, drive STB_1..STB_6 with no fetch -> DONE=1 only on STB_6, FAULT=1, ICOUNT=0; FAULT stays 1 across the next good instruction and clears on RESET.
- Reset and wrap: RESET asserted mid-ISZ after STB_2 -> next cycle IR=0, PHASE=0, DONE=0; separately preload ICOUNT to 16'hFFFF, retire one instruction -> ICOUNT=0.
